alu_exec_unit: RTL and testbench

- Execute-stage ALU that consumes the 4-bit operation_code produced by the ALU control stage, plus two register/immediate operands.
- Single-cycle ops (AND, OR, ADD, SUB, SLL) complete in one clock.
- MUL runs on an iterative shift-add datapath over WIDTH clocks, with busy/done handshake so the pipeline control can stall.
- Result and zero flag are registered and feed writeback and branch resolution.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/mul_shift_add.sv | 50 +++++
 rtl/alu_exec_unit.sv | 123 ++++++++++++
 tb/tb_alu_exec_unit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation encodings from the ALU control stage and the
// execute-unit state type.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b1101;
    localparam logic [3:0] ALU_MUL = 4'b1010;

    typedef enum logic {
        IDLE,
        MUL_RUN
    } alu_state_t;

    function automatic logic is_single_cycle_op(input logic [3:0] op);
        return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) ||
               (op == ALU_SUB) || (op == ALU_SLL);
    endfunction

endpackage

// File: rtl/mul_shift_add.sv
// Iterative shift-add multiplier: one multiplier bit per clock, fixed WIDTH
// iterations after a load, producing the low WIDTH bits of the product.
module mul_shift_add
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_mcand,
    input  logic [WIDTH-1:0] i_mplier,
    output logic [WIDTH-1:0] o_acc,
    output logic             o_last
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [CNT_W-1:0] r_count;
    logic [WIDTH-1:0] w_acc_next;

    // o_acc already includes this cycle's partial product, so on the last
    // iteration it is the final product the top can register directly.
    assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
    assign o_acc      = w_acc_next;
    assign o_last     = (r_count == CNT_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
            r_count  <= '0;
        end else if (i_load) begin
            r_mcand  <= i_mcand;
            r_mplier <= i_mplier;
            r_acc    <= '0;
            r_count  <= CNT_W'(WIDTH);
        end else if (r_count != '0) begin
            r_acc    <= w_acc_next;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count - CNT_W'(1);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arithmetic/shift ops plus an iterative
// MUL with busy/done handshake; result and zero flag are registered.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       operation_code,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             done,
    output logic             busy,
    output logic             illegal_op
);

    alu_state_t       r_state;
    alu_state_t       w_state_next;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_done;
    logic             r_illegal;

    logic [WIDTH-1:0] w_result_next;
    logic             w_zero_next;
    logic             w_done_next;
    logic             w_illegal_next;
    logic             w_load;
    logic [WIDTH-1:0] w_alu_value;
    logic [WIDTH-1:0] w_mul_acc;
    logic             w_mul_last;

    mul_shift_add #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_mcand  (operand_a),
        .i_mplier (operand_b),
        .o_acc    (w_mul_acc),
        .o_last   (w_mul_last)
    );

    always_comb begin
        w_alu_value = '0;
        case (operation_code)
            ALU_AND: w_alu_value = operand_a & operand_b;
            ALU_OR:  w_alu_value = operand_a | operand_b;
            ALU_ADD: w_alu_value = operand_a + operand_b;
            ALU_SUB: w_alu_value = operand_a - operand_b;
            ALU_SLL: w_alu_value = operand_a << operand_b[SHAMT_W-1:0];
            default: w_alu_value = '0;
        endcase
    end

    // Illegal codes complete like a single-cycle op but force a zero result.
    always_comb begin
        w_state_next   = r_state;
        w_result_next  = r_result;
        w_zero_next    = r_zero;
        w_done_next    = 1'b0;
        w_illegal_next = 1'b0;
        w_load         = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    if (operation_code == ALU_MUL) begin
                        w_load       = 1'b1;
                        w_state_next = MUL_RUN;
                    end else begin
                        w_done_next = 1'b1;
                        if (is_single_cycle_op(operation_code)) begin
                            w_result_next = w_alu_value;
                            w_zero_next   = (w_alu_value == '0);
                        end else begin
                            w_result_next  = '0;
                            w_zero_next    = 1'b1;
                            w_illegal_next = 1'b1;
                        end
                    end
                end
            end
            MUL_RUN: begin
                if (w_mul_last) begin
                    w_result_next = w_mul_acc;
                    w_zero_next   = (w_mul_acc == '0);
                    w_done_next   = 1'b1;
                    w_state_next  = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_result  <= '0;
            r_zero    <= 1'b1;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_result  <= w_result_next;
            r_zero    <= w_zero_next;
            r_done    <= w_done_next;
            r_illegal <= w_illegal_next;
        end
    end

    assign result     = r_result;
    assign zero       = r_zero;
    assign done       = r_done;
    assign illegal_op = r_illegal;
    assign busy       = (r_state == MUL_RUN);

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: table of single-cycle vectors plus
// hand-written MUL, back-to-back, busy-ignore and mid-MUL reset sequences.
module tb_alu_exec_unit;

    localparam int WIDTH = 32;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b1101;
    localparam logic [3:0] OP_MUL = 4'b1010;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [3:0]       operation_code;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             done;
    logic             busy;
    logic             illegal_op;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expResult;
        logic        expZero;
        logic        expIllegal;
    } vec_t;

    vec_t vecs[10];

    alu_exec_unit #(.WIDTH(WIDTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .operation_code (operation_code),
        .operand_a      (operand_a),
        .operand_b      (operand_b),
        .result         (result),
        .zero           (zero),
        .done           (done),
        .busy           (busy),
        .illegal_op     (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one request at the falling edge, returns 1 ns after the accepting edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
        @(negedge clk);
        start          = 1'b1;
        operation_code = op;
        operand_a      = a;
        operand_b      = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runMul(input string name, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected,
                          input bit disturb);
        int lat;
        int busyCycles;
        applyStimulus(OP_MUL, a, b);
        checkOutput({name, "_busy_at_load"}, 32'(busy), 32'd1);
        checkOutput({name, "_no_done_at_load"}, 32'(done), 32'd0);
        busyCycles = 1;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
            if (busy) busyCycles++;
            if (disturb) begin
                if (lat == 5) begin
                    start          = 1'b1;
                    operation_code = OP_ADD;
                    operand_a      = 32'hFFFF_FFFF;
                    operand_b      = 32'h0000_0001;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checkOutput({name, "_latency"}, 32'(lat), 32'd32);
        checkOutput({name, "_busy_cycles"}, 32'(busyCycles), 32'd32);
        checkOutput({name, "_result"}, result, expected);
        checkOutput({name, "_zero"}, 32'(zero), 32'(expected == 32'd0));
        checkOutput({name, "_busy_cleared"}, 32'(busy), 32'd0);
        checkOutput({name, "_illegal"}, 32'(illegal_op), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int doneSeen;

        vecs[0] = '{"add_overflow_sign", OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0};
        vecs[1] = '{"sub_equal",         OP_SUB, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0};
        vecs[2] = '{"sll_upper_ignored", OP_SLL, 32'h0000_0001, 32'hFFFF_FFE4, 32'h0000_0010, 1'b0, 1'b0};
        vecs[3] = '{"and_pattern",       OP_AND, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
        vecs[4] = '{"or_pattern",        OP_OR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFFF0_FFF0, 1'b0, 1'b0};
        vecs[5] = '{"illegal_1111",      4'b1111, 32'h0000_007B, 32'h0000_01C8, 32'h0000_0000, 1'b1, 1'b1};
        vecs[6] = '{"add_wrap_zero",     OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b0};
        vecs[7] = '{"sub_underflow",     OP_SUB, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[8] = '{"sll_max_shamt",     OP_SLL, 32'h0000_0003, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0};
        vecs[9] = '{"illegal_0011",      4'b0011, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b1};

        rst_n          = 1'b1;
        start          = 1'b0;
        operation_code = 4'b0000;
        operand_a      = '0;
        operand_b      = '0;
        #2;
        rst_n = 1'b0;
        #2;
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_illegal", 32'(illegal_op), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            checkOutput({vecs[i].name, "_done"}, 32'(done), 32'd1);
            checkOutput({vecs[i].name, "_result"}, result, vecs[i].expResult);
            checkOutput({vecs[i].name, "_zero"}, 32'(zero), 32'(vecs[i].expZero));
            checkOutput({vecs[i].name, "_illegal"}, 32'(illegal_op), 32'(vecs[i].expIllegal));
            checkOutput({vecs[i].name, "_busy"}, 32'(busy), 32'd0);
            @(posedge clk);
            #1;
            checkOutput({vecs[i].name, "_done_pulse_end"}, 32'(done), 32'd0);
            checkOutput({vecs[i].name, "_illegal_pulse_end"}, 32'(illegal_op), 32'd0);
            checkOutput({vecs[i].name, "_result_hold"}, result, vecs[i].expResult);
        end

        runMul("mul_neg1_x7", 32'hFFFF_FFFF, 32'h0000_0007, 32'hFFFF_FFF9, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("mul_neg1_x7_done_pulse_end", 32'(done), 32'd0);
        checkOutput("mul_neg1_x7_result_hold", result, 32'hFFFF_FFF9);

        runMul("mul_disturbed", 32'd12345, 32'd6789, 32'd83810205, 1'b1);
        start          = 1'b1;
        operation_code = OP_ADD;
        operand_a      = 32'd10;
        operand_b      = 32'd20;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("b2b_add_done", 32'(done), 32'd1);
        checkOutput("b2b_add_result", result, 32'd30);
        checkOutput("b2b_add_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("b2b_add_done_pulse_end", 32'(done), 32'd0);

        applyStimulus(OP_MUL, 32'd12345, 32'd6789);
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midmul_reset_result", result, 32'd0);
        checkOutput("midmul_reset_zero", 32'(zero), 32'd1);
        checkOutput("midmul_reset_busy", 32'(busy), 32'd0);
        checkOutput("midmul_reset_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        doneSeen = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk);
            #1;
            if (done || busy) doneSeen++;
        end
        checkOutput("midmul_no_done_after_reset", 32'(doneSeen), 32'd0);
        checkOutput("midmul_result_still_reset", result, 32'd0);

        runMul("mul_after_reset", 32'd3, 32'd5, 32'd15, 1'b0);
        runMul("mul_wrap_zero", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
